// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, T-states and control-word layout shared by the CPU control path
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;
    localparam logic [2:0] T5 = 3'd5;

    localparam int CW_PC_INC     = 0;
    localparam int CW_PC_OUT     = 1;
    localparam int CW_PC_LOAD_N  = 2;
    localparam int CW_MAR_LOAD_N = 3;
    localparam int CW_RAM_OUT    = 4;
    localparam int CW_IR_LOAD_N  = 5;
    localparam int CW_IR_OUT     = 6;
    localparam int CW_A_LOAD_N   = 7;
    localparam int CW_A_OUT      = 8;
    localparam int CW_B_LOAD_N   = 9;
    localparam int CW_ALU_OUT    = 10;
    localparam int CW_ALU_SUB    = 11;
    localparam int CW_FLAGS_LOAD = 12;
    localparam int CW_OUT_LOAD_N = 13;
    localparam int CW_W          = 14;

    typedef logic [CW_W-1:0] ctrl_word_t;

    // Active-low loads parked high, every enable low.
    localparam ctrl_word_t CW_IDLE = (ctrl_word_t'(1) << CW_PC_LOAD_N)
                                   | (ctrl_word_t'(1) << CW_MAR_LOAD_N)
                                   | (ctrl_word_t'(1) << CW_IR_LOAD_N)
                                   | (ctrl_word_t'(1) << CW_A_LOAD_N)
                                   | (ctrl_word_t'(1) << CW_B_LOAD_N)
                                   | (ctrl_word_t'(1) << CW_OUT_LOAD_N);

endpackage

// File: rtl/ring_counter.sv
// rtl/ring_counter.sv - T-state counter that wraps every NUM_T cycles and freezes once halted
module ring_counter
    import cpu_pkg::*;
#(
    parameter int NUM_T = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       halt_req,
    output logic [2:0] tstate,
    output logic       halted
);

    localparam logic [2:0] T_LAST = 3'(NUM_T - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tstate <= T0;
            halted <= 1'b0;
        end else if (halted || halt_req) begin
            halted <= 1'b1;
        end else if (tstate == T_LAST) begin
            tstate <= T0;
        end else begin
            tstate <= tstate + 3'd1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/execute strobe decode for the shared-bus CPU; CTRL_JUMP_EN enables JMP/JC/JZ
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int NUM_T = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic       pc_inc,
    output logic       pc_out,
    output logic       pc_load_n,
    output logic       mar_load_n,
    output logic       ram_out,
    output logic       ir_load_n,
    output logic       ir_out,
    output logic       a_load_n,
    output logic       a_out,
    output logic       b_load_n,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       flags_load,
    output logic       out_load_n,
    output logic       halt,
    output logic [2:0] tstate
);

    logic       halted;
    logic       halt_req;
    logic       jump_taken;
    ctrl_word_t cw;
    ctrl_word_t ctrl;

    assign halt_req = (tstate == T3) && (opcode == OP_HLT);
    assign halt     = halted || halt_req;

    ring_counter #(.NUM_T(NUM_T)) u_ring_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .halt_req (halt_req),
        .tstate   (tstate),
        .halted   (halted)
    );

`ifdef CTRL_JUMP_EN
    assign jump_taken = (opcode == OP_JMP)
                     || ((opcode == OP_JC) && carry_flag)
                     || ((opcode == OP_JZ) && zero_flag);
`else
    assign jump_taken = 1'b0;
    wire unused_flags = carry_flag ^ zero_flag;
`endif

    // Each state enables at most one bus driver; unlisted opcodes fall through to idle.
    always_comb begin
        cw = CW_IDLE;
        if (!halt) begin
            case (tstate)
                T0: begin
                    cw[CW_PC_OUT]     = 1'b1;
                    cw[CW_MAR_LOAD_N] = 1'b0;
                end
                T1: cw[CW_PC_INC] = 1'b1;
                T2: begin
                    cw[CW_RAM_OUT]   = 1'b1;
                    cw[CW_IR_LOAD_N] = 1'b0;
                end
                T3: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            cw[CW_IR_OUT]     = 1'b1;
                            cw[CW_MAR_LOAD_N] = 1'b0;
                        end
                        OP_LDI: begin
                            cw[CW_IR_OUT]   = 1'b1;
                            cw[CW_A_LOAD_N] = 1'b0;
                        end
                        OP_OUT: begin
                            cw[CW_A_OUT]      = 1'b1;
                            cw[CW_OUT_LOAD_N] = 1'b0;
                        end
                        default: begin
                            if (jump_taken) begin
                                cw[CW_IR_OUT]    = 1'b1;
                                cw[CW_PC_LOAD_N] = 1'b0;
                            end
                        end
                    endcase
                end
                T4: begin
                    case (opcode)
                        OP_LDA: begin
                            cw[CW_RAM_OUT]  = 1'b1;
                            cw[CW_A_LOAD_N] = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            cw[CW_RAM_OUT]  = 1'b1;
                            cw[CW_B_LOAD_N] = 1'b0;
                            cw[CW_ALU_SUB]  = (opcode == OP_SUB);
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        cw[CW_ALU_OUT]    = 1'b1;
                        cw[CW_A_LOAD_N]   = 1'b0;
                        cw[CW_FLAGS_LOAD] = 1'b1;
                        cw[CW_ALU_SUB]    = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    // Reset idles the strobes combinationally so T0 drivers stay off while rst_n is low.
    assign ctrl = rst_n ? cw : CW_IDLE;

    assign pc_inc     = ctrl[CW_PC_INC];
    assign pc_out     = ctrl[CW_PC_OUT];
    assign mar_load_n = ctrl[CW_MAR_LOAD_N];
    assign ram_out    = ctrl[CW_RAM_OUT];
    assign ir_load_n  = ctrl[CW_IR_LOAD_N];
    assign ir_out     = ctrl[CW_IR_OUT];
    assign a_load_n   = ctrl[CW_A_LOAD_N];
    assign a_out      = ctrl[CW_A_OUT];
    assign b_load_n   = ctrl[CW_B_LOAD_N];
    assign alu_out    = ctrl[CW_ALU_OUT];
    assign alu_sub    = ctrl[CW_ALU_SUB];
    assign flags_load = ctrl[CW_FLAGS_LOAD];
    assign out_load_n = ctrl[CW_OUT_LOAD_N];

`ifdef CTRL_JUMP_EN
    assign pc_load_n = ctrl[CW_PC_LOAD_N];
`else
    assign pc_load_n = 1'b1;
    wire unused_pc_load = ctrl[CW_PC_LOAD_N];
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed-vector bench for control_sequencer
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       carry_flag = 1'b0;
    logic       zero_flag = 1'b0;
    logic       pc_inc, pc_out, pc_load_n, mar_load_n, ram_out, ir_load_n, ir_out;
    logic       a_load_n, a_out, b_load_n, alu_out, alu_sub, flags_load, out_load_n, halt;
    logic [2:0] tstate;

    int n_cmp = 0;
    int n_bad = 0;

    control_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .pc_inc     (pc_inc),
        .pc_out     (pc_out),
        .pc_load_n  (pc_load_n),
        .mar_load_n (mar_load_n),
        .ram_out    (ram_out),
        .ir_load_n  (ir_load_n),
        .ir_out     (ir_out),
        .a_load_n   (a_load_n),
        .a_out      (a_out),
        .b_load_n   (b_load_n),
        .alu_out    (alu_out),
        .alu_sub    (alu_sub),
        .flags_load (flags_load),
        .out_load_n (out_load_n),
        .halt       (halt),
        .tstate     (tstate)
    );

    always #5 clk = ~clk;

    localparam logic [14:0] M_PC_INC  = 15'h4000;
    localparam logic [14:0] M_PC_OUT  = 15'h2000;
    localparam logic [14:0] M_PC_LD   = 15'h1000;
    localparam logic [14:0] M_MAR     = 15'h0800;
    localparam logic [14:0] M_RAM     = 15'h0400;
    localparam logic [14:0] M_IR_LD   = 15'h0200;
    localparam logic [14:0] M_IR_OUT  = 15'h0100;
    localparam logic [14:0] M_A_LD    = 15'h0080;
    localparam logic [14:0] M_A_OUT   = 15'h0040;
    localparam logic [14:0] M_B_LD    = 15'h0020;
    localparam logic [14:0] M_ALU_OUT = 15'h0010;
    localparam logic [14:0] M_SUB     = 15'h0008;
    localparam logic [14:0] M_FLAGS   = 15'h0004;
    localparam logic [14:0] M_OUT_LD  = 15'h0002;
    localparam logic [14:0] M_HALT    = 15'h0001;
    localparam logic [14:0] IDLE      = M_PC_LD | M_MAR | M_IR_LD | M_A_LD | M_B_LD | M_OUT_LD;

    // Load strobe bits sit at their idle 1; XOR with a mask flips a bit to its active level.
    localparam logic [14:0] F_T0 = IDLE ^ M_PC_OUT ^ M_MAR;
    localparam logic [14:0] F_T1 = IDLE ^ M_PC_INC;
    localparam logic [14:0] F_T2 = IDLE ^ M_RAM ^ M_IR_LD;
    localparam logic [14:0] JUMP = IDLE ^ M_IR_OUT ^ M_PC_LD;

    logic [14:0] obs;
    logic [2:0]  bus_cnt;
    assign obs = {pc_inc, pc_out, pc_load_n, mar_load_n, ram_out, ir_load_n, ir_out,
                  a_load_n, a_out, b_load_n, alu_out, alu_sub, flags_load, out_load_n, halt};
    assign bus_cnt = 3'(pc_out) + 3'(ram_out) + 3'(ir_out) + 3'(a_out) + 3'(alu_out);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [14:0] exp, input logic [2:0] t);
        check_eq({tag, "_cw"}, 32'(obs), 32'(exp));
        check_eq({tag, "_t"}, 32'(tstate), 32'(t));
        @(negedge clk);
        #1;
    endtask

    task automatic instr(input string tag, input logic [3:0] op, input logic c, input logic z,
                         input logic [14:0] e3, input logic [14:0] e4, input logic [14:0] e5);
        opcode = op;
        carry_flag = c;
        zero_flag = z;
        step({tag, "_T0"}, F_T0, 3'd0);
        step({tag, "_T1"}, F_T1, 3'd1);
        step({tag, "_T2"}, F_T2, 3'd2);
        step({tag, "_T3"}, e3, 3'd3);
        step({tag, "_T4"}, e4, 3'd4);
        step({tag, "_T5"}, e5, 3'd5);
    endtask

    initial begin
        logic [14:0] j_exp;
        logic        nop_like;

        #1;
        check_eq("reset_cw", 32'(obs), 32'(IDLE));
        check_eq("reset_t", 32'(tstate), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;

        instr("nop", 4'h0, 1'b0, 1'b0, IDLE, IDLE, IDLE);
        instr("add", 4'h2, 1'b0, 1'b0, IDLE ^ M_IR_OUT ^ M_MAR, IDLE ^ M_RAM ^ M_B_LD,
              IDLE ^ M_ALU_OUT ^ M_A_LD ^ M_FLAGS);
        instr("sub", 4'h3, 1'b0, 1'b0, IDLE ^ M_IR_OUT ^ M_MAR, IDLE ^ M_RAM ^ M_B_LD ^ M_SUB,
              IDLE ^ M_ALU_OUT ^ M_A_LD ^ M_FLAGS ^ M_SUB);
        instr("lda", 4'h1, 1'b0, 1'b0, IDLE ^ M_IR_OUT ^ M_MAR, IDLE ^ M_RAM ^ M_A_LD, IDLE);
        instr("ldi", 4'h5, 1'b0, 1'b0, IDLE ^ M_IR_OUT ^ M_A_LD, IDLE, IDLE);
        instr("out", 4'hE, 1'b0, 1'b0, IDLE ^ M_A_OUT ^ M_OUT_LD, IDLE, IDLE);

`ifdef CTRL_JUMP_EN
        j_exp = JUMP;
`else
        j_exp = IDLE;
`endif
        instr("jmp", 4'h6, 1'b0, 1'b0, j_exp, IDLE, IDLE);
        instr("jc_taken", 4'h7, 1'b1, 1'b0, j_exp, IDLE, IDLE);
        instr("jc_not", 4'h7, 1'b0, 1'b1, IDLE, IDLE, IDLE);
        instr("jz_taken", 4'h8, 1'b0, 1'b1, j_exp, IDLE, IDLE);
        instr("jz_not", 4'h8, 1'b1, 1'b0, IDLE, IDLE, IDLE);

        // Asynchronous reset landing in the middle of LDA's T4.
        opcode = 4'h1;
        step("lda_r_T0", F_T0, 3'd0);
        step("lda_r_T1", F_T1, 3'd1);
        step("lda_r_T2", F_T2, 3'd2);
        step("lda_r_T3", IDLE ^ M_IR_OUT ^ M_MAR, 3'd3);
        check_eq("lda_r_T4_cw", 32'(obs), 32'(IDLE ^ M_RAM ^ M_A_LD));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midreset_cw", 32'(obs), 32'(IDLE));
        check_eq("midreset_t", 32'(tstate), 32'd0);
        @(negedge clk);
        #1;
        check_eq("midreset_hold_cw", 32'(obs), 32'(IDLE));
        rst_n = 1'b1;
        #1;
        instr("refetch", 4'h0, 1'b0, 1'b0, IDLE, IDLE, IDLE);

        // Every non-halting opcode: bus stays one-hot-or-empty, undefined opcodes behave as NOP.
        for (int op = 0; op < 15; op++) begin
            opcode = 4'(op);
            carry_flag = 1'b1;
            zero_flag = 1'b1;
            nop_like = (op == 4) || (op >= 9 && op <= 13);
`ifndef CTRL_JUMP_EN
            nop_like = nop_like || (op >= 6 && op <= 8);
`endif
            for (int t = 0; t < 6; t++) begin
                check_eq($sformatf("bus_op%0h_t%0d", op, t), 32'(bus_cnt <= 3'd1), 32'd1);
                if (nop_like && t >= 3)
                    check_eq($sformatf("nop_op%0h_t%0d", op, t), 32'(obs), 32'(IDLE));
                @(negedge clk);
                #1;
            end
        end

        opcode = 4'hF;
        step("hlt_T0", F_T0, 3'd0);
        step("hlt_T1", F_T1, 3'd1);
        step("hlt_T2", F_T2, 3'd2);
        check_eq("hlt_T3_cw", 32'(obs), 32'(IDLE ^ M_HALT));
        @(negedge clk);
        #1;
        opcode = 4'h2;
        for (int i = 0; i < 20; i++) begin
            check_eq($sformatf("halted_cw_%0d", i), 32'(obs), 32'(IDLE ^ M_HALT));
            check_eq($sformatf("halted_t_%0d", i), 32'(tstate), 32'd3);
            @(negedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check_eq("unhalt_t", 32'(tstate), 32'd0);
        check_eq("unhalt_halt", 32'(halt), 32'd0);
        check_eq("unhalt_cw", 32'(obs), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        instr("post_halt", 4'h0, 1'b0, 1'b0, IDLE, IDLE, IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
